// File: rtl/serial_word_feeder.sv
// serial_word_feeder
//   Upstream stage of the serial two's-complement inverter. Accepts parallel
//   words over a valid/ready handshake and shifts them out LSB-first, one bit
//   per t_clk. Each word is preceded by a one-cycle seq_clr pulse that restarts
//   the inverter, so every word is complemented independently.
//
//   Optional feature macro: SERIAL_FEEDER_PREFETCH_EN
//     defined   : one-word holding register; words run back-to-back with a
//                 single seq_clr cycle between them (WIDTH+1 cycles per word).
//     undefined : in_ready only in IDLE; one IDLE cycle between words
//                 (WIDTH+2 cycles per word).
//
// Parameters
//   WIDTH      word length in bits (2..32)
// Ports
//   t_clk      in   system clock, rising edge
//   r          in   asynchronous active-high reset
//   in_data    in   parallel word, bit 0 = LSB
//   in_valid   in   in_data valid
//   in_ready   out  word accepted this cycle when in_valid is high
//   ser_bit    out  serial data bit (registered)
//   bit_valid  out  ser_bit carries a data bit (registered)
//   seq_clr    out  inverter restart, the cycle before bit 0 (registered)
//   word_done  out  pulse in the cycle carrying bit WIDTH-1 (registered)
module serial_word_feeder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             bit_valid,
  output logic             seq_clr,
  output logic             word_done
);

  localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             ser_bit_n, bit_valid_n, seq_clr_n, word_done_n;
  logic             take;

`ifdef SERIAL_FEEDER_PREFETCH_EN
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_v, hold_v_n;
`endif

  // in_ready is the only unregistered output; it is decoded from state and
  // held low for as long as reset is applied.
  always_comb begin
    in_ready = 1'b0;
    if (!r) begin
      unique case (state)
        IDLE:       in_ready = 1'b1;
`ifdef SERIAL_FEEDER_PREFETCH_EN
        CLR, SHIFT: in_ready = ~hold_v;
`else
        CLR, SHIFT: in_ready = 1'b0;
`endif
        default:    in_ready = 1'b0;
      endcase
    end
  end

  assign take = in_valid & in_ready;

  // Outputs are registered, so each branch computes what the next cycle
  // shows: the edge leaving CLR already presents bit 0, and cnt tracks the
  // index of the bit currently on ser_bit.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    cnt_n       = cnt;
    ser_bit_n   = 1'b0;
    bit_valid_n = 1'b0;
    seq_clr_n   = 1'b0;
    word_done_n = 1'b0;
`ifdef SERIAL_FEEDER_PREFETCH_EN
    hold_n      = hold;
    hold_v_n    = hold_v;
    if (take && (state != IDLE)) begin
      hold_n   = in_data;
      hold_v_n = 1'b1;
    end
`endif

    unique case (state)
      IDLE: begin
        if (take) begin
          shreg_n   = in_data;
          cnt_n     = '0;
          seq_clr_n = 1'b1;
          state_n   = CLR;
        end
      end

      CLR: begin
        ser_bit_n   = shreg[0];
        bit_valid_n = 1'b1;
        shreg_n     = shreg >> 1;
        cnt_n       = '0;
        word_done_n = (LAST == '0);
        state_n     = SHIFT;
      end

      SHIFT: begin
        if (cnt != LAST) begin
          ser_bit_n   = shreg[0];
          bit_valid_n = 1'b1;
          shreg_n     = shreg >> 1;
          cnt_n       = cnt + CW'(1);
          word_done_n = (cnt_n == LAST);
        end else begin
`ifdef SERIAL_FEEDER_PREFETCH_EN
          // A word arriving on the very edge of the last bit bypasses hold
          // so it is not stranded when the FSM would otherwise go idle.
          if (hold_v) begin
            shreg_n   = hold;
            hold_v_n  = 1'b0;
            cnt_n     = '0;
            seq_clr_n = 1'b1;
            state_n   = CLR;
          end else if (take) begin
            shreg_n   = in_data;
            hold_v_n  = 1'b0;
            cnt_n     = '0;
            seq_clr_n = 1'b1;
            state_n   = CLR;
          end else begin
            state_n   = IDLE;
          end
`else
          state_n = IDLE;
`endif
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      ser_bit   <= 1'b0;
      bit_valid <= 1'b0;
      seq_clr   <= 1'b0;
      word_done <= 1'b0;
`ifdef SERIAL_FEEDER_PREFETCH_EN
      hold      <= '0;
      hold_v    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      ser_bit   <= ser_bit_n;
      bit_valid <= bit_valid_n;
      seq_clr   <= seq_clr_n;
      word_done <= word_done_n;
`ifdef SERIAL_FEEDER_PREFETCH_EN
      hold      <= hold_n;
      hold_v    <= hold_v_n;
`endif
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// tb_serial_word_feeder
//   Directed bench for serial_word_feeder at WIDTH=8 and WIDTH=4. Stimulus
//   pushes the expected serial bits, word_done flags and inverter outputs into
//   per-instance queues; negedge monitors pop and compare whenever bit_valid
//   is high, and log seq_clr / word_done cycles for latency checks.
module tb_serial_word_feeder;

  logic t_clk = 1'b0;
  always #5 t_clk = ~t_clk;

  logic       r;
  logic [7:0] d8;
  logic       v8, rdy8, sb8, bv8, sc8, wd8;
  logic [3:0] d4;
  logic       v4, rdy4, sb4, bv4, sc4, wd4;

  serial_word_feeder #(.WIDTH(8)) u8 (
    .t_clk(t_clk), .r(r), .in_data(d8), .in_valid(v8), .in_ready(rdy8),
    .ser_bit(sb8), .bit_valid(bv8), .seq_clr(sc8), .word_done(wd8)
  );

  serial_word_feeder #(.WIDTH(4)) u4 (
    .t_clk(t_clk), .r(r), .in_data(d4), .in_valid(v4), .in_ready(rdy4),
    .ser_bit(sb4), .bit_valid(bv4), .seq_clr(sc4), .word_done(wd4)
  );

  typedef struct {
    logic b;
    logic d;
    logic y;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int   clr8[$], done8[$], clr4[$], done4[$];
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   busy_rdy8 = 0;
  logic seen8     = 1'b0;
  logic seen4     = 1'b0;

  always @(posedge t_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 8-bit instance; y models the downstream inverter
  // (pass bits up to and including the first 1, invert after).
  always @(negedge t_clk) begin : mon8
    exp_t e;
    logic y;
    if (sc8 === 1'b1) begin
      clr8.push_back(cyc);
      seen8 = 1'b0;
    end
    if (wd8 === 1'b1) begin
      done8.push_back(cyc);
      chk("done_has_valid8", bv8, 1);
    end
    if ((sc8 === 1'b1 || bv8 === 1'b1) && rdy8 === 1'b1) busy_rdy8++;
    if (bv8 === 1'b1) begin
      if (q8.size() == 0) begin
        chk("unexpected_bit8", bv8, 0);
      end else begin
        e = q8.pop_front();
        y = sb8 ^ seen8;
        seen8 = seen8 | sb8;
        chk("bit8", sb8, e.b);
        chk("word_done8", wd8, e.d);
        chk("inv_y8", y, e.y);
      end
    end
  end

  always @(negedge t_clk) begin : mon4
    exp_t e;
    logic y;
    if (sc4 === 1'b1) begin
      clr4.push_back(cyc);
      seen4 = 1'b0;
    end
    if (wd4 === 1'b1) begin
      done4.push_back(cyc);
      chk("done_has_valid4", bv4, 1);
    end
    if (bv4 === 1'b1) begin
      if (q4.size() == 0) begin
        chk("unexpected_bit4", bv4, 0);
      end else begin
        e = q4.pop_front();
        y = sb4 ^ seen4;
        seen4 = seen4 | sb4;
        chk("bit4", sb4, e.b);
        chk("word_done4", wd4, e.d);
        chk("inv_y4", y, e.y);
      end
    end
  end

  // Queue the first nbits of w (with the inverter output word y) and present
  // w until accepted. acc = index of the accepting edge. in_valid is left high.
  task automatic send8(input logic [7:0] w, input logic [7:0] y, input int nbits, output int acc);
    exp_t e;
    for (int i = 0; i < nbits; i++) begin
      e.b = w[i];
      e.d = (i == 7);
      e.y = y[i];
      q8.push_back(e);
    end
    @(negedge t_clk);
    d8 = w;
    v8 = 1'b1;
    acc = -1;
    for (int t = 0; t < 100; t++) begin
      if (rdy8 === 1'b1) begin
        @(posedge t_clk);
        #1;
        acc = cyc;
        break;
      end
      @(negedge t_clk);
    end
    chk("accepted8", acc >= 0, 1);
  endtask

  task automatic send4(input logic [3:0] w, input logic [3:0] y, output int acc);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.b = w[i];
      e.d = (i == 3);
      e.y = y[i];
      q4.push_back(e);
    end
    @(negedge t_clk);
    d4 = w;
    v4 = 1'b1;
    acc = -1;
    for (int t = 0; t < 100; t++) begin
      if (rdy4 === 1'b1) begin
        @(posedge t_clk);
        #1;
        acc = cyc;
        break;
      end
      @(negedge t_clk);
    end
    chk("accepted4", acc >= 0, 1);
  endtask

  task automatic drain8();
    for (int t = 0; t < 200; t++) begin
      @(negedge t_clk);
      #1;
      if (q8.size() == 0 && bv8 !== 1'b1 && sc8 !== 1'b1) break;
    end
    chk("drain8", q8.size(), 0);
  endtask

  task automatic drain4();
    for (int t = 0; t < 200; t++) begin
      @(negedge t_clk);
      #1;
      if (q4.size() == 0 && bv4 !== 1'b1 && sc4 !== 1'b1) break;
    end
    chk("drain4", q4.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : main
    int k, k2;

    // Reset with in_valid asserted: nothing may be captured.
    r  = 1'b1;
    v8 = 1'b1; d8 = 8'hAA;
    v4 = 1'b1; d4 = 4'h5;
    repeat (2) @(posedge t_clk);
    @(negedge t_clk);
    chk("rst_in_ready8", rdy8, 0);
    chk("rst_ser_bit8", sb8, 0);
    chk("rst_bit_valid8", bv8, 0);
    chk("rst_seq_clr8", sc8, 0);
    chk("rst_word_done8", wd8, 0);
    chk("rst_in_ready4", rdy4, 0);
    v8 = 1'b0;
    v4 = 1'b0;
    r  = 1'b0;
    @(negedge t_clk);
    chk("idle_in_ready8", rdy8, 1);
    chk("idle_in_ready4", rdy4, 1);
    chk("no_capture_valid8", bv8, 0);
    chk("no_capture_clr8", sc8, 0);

    // 8'hB4 -> bits 0,0,1,0,1,1,0,1; inverter gives 8'h4C.
    clr8.delete(); done8.delete();
    send8(8'hB4, 8'h4C, 8, k);
    @(negedge t_clk);
    v8 = 1'b0;
    drain8();
    chk("b4_clr_count", clr8.size(), 1);
    chk("b4_done_count", done8.size(), 1);
    if (clr8.size() > 0)  chk("b4_clr_cycle", clr8[0], k);
    if (done8.size() > 0) chk("b4_done_cycle", done8[0], k + 8);

    // 8'h01 then 8'h80 with in_valid held high.
    clr8.delete(); done8.delete();
    busy_rdy8 = 0;
    send8(8'h01, 8'hFF, 8, k);
    send8(8'h80, 8'h80, 8, k2);
    @(negedge t_clk);
    v8 = 1'b0;
    drain8();
    chk("pair_clr_count", clr8.size(), 2);
    chk("pair_done_count", done8.size(), 2);
    if (clr8.size() == 2 && done8.size() == 2) begin
`ifdef SERIAL_FEEDER_PREFETCH_EN
      chk("pf_clr_gap", clr8[1] - done8[0], 1);
      chk("pf_span", done8[1] - clr8[0] + 1, 18);
`else
      chk("base_clr_gap", clr8[1] - done8[0], 2);
      chk("base_span", done8[1] - clr8[0] + 1, 19);
      chk("base_busy_in_ready", busy_rdy8, 0);
`endif
    end

    // Abort 8'hFF during bit 3: bits 0..2 seen, then async clear.
    clr8.delete(); done8.delete();
    send8(8'hFF, 8'h01, 3, k);
    @(negedge t_clk);
    v8 = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (q8.size() == 0) break;
      @(negedge t_clk);
      #1;
    end
    chk("abort_pre_bits", q8.size(), 0);
    @(posedge t_clk);
    #1;
    chk("abort_bit3_valid", bv8, 1);
    r = 1'b1;
    #1;
    chk("abort_async_valid", bv8, 0);
    chk("abort_async_ser", sb8, 0);
    chk("abort_async_clr", sc8, 0);
    chk("abort_async_done", wd8, 0);
    chk("abort_in_ready", rdy8, 0);
    repeat (2) @(negedge t_clk);
    chk("abort_no_done", done8.size(), 0);
    r = 1'b0;
    #1;
    chk("abort_idle_ready", rdy8, 1);

    // 8'h02 after the abort -> bits 0,1,0,0,0,0,0,0; inverter gives 8'hFE.
    clr8.delete(); done8.delete();
    send8(8'h02, 8'hFE, 8, k);
    @(negedge t_clk);
    v8 = 1'b0;
    drain8();
    chk("w02_done_count", done8.size(), 1);
    if (done8.size() > 0) chk("w02_done_cycle", done8[0], k + 8);

    // WIDTH=4, 4'h8 -> bits 0,0,0,1; most-negative value is self-complement.
    clr4.delete(); done4.delete();
    send4(4'h8, 4'h8, k);
    @(negedge t_clk);
    v4 = 1'b0;
    drain4();
    chk("w4_clr_count", clr4.size(), 1);
    chk("w4_done_count", done4.size(), 1);
    if (clr4.size() > 0)  chk("w4_clr_cycle", clr4[0], k);
    if (done4.size() > 0) chk("w4_done_cycle", done4[0], k + 4);

    repeat (3) @(negedge t_clk);
    chk("final_q8_empty", q8.size(), 0);
    chk("final_q4_empty", q4.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
